// File: rtl/gba_dsound_pkg.sv
// gba_dsound_pkg: shared constants and helpers for the direct-sound engine
package gba_dsound_pkg;
  localparam int MAX_CH = 8;
  function automatic int tsel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction
  function automatic logic signed [9:0] vol_scale(input logic [7:0] s, input logic full);
    return full ? {s[7], s, 1'b0} : {{2{s[7]}}, s};
  endfunction
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] mx, mn;
    mx = (32'sd1 <<< (w - 1)) - 32'sd1;
    mn = -mx - 32'sd1;
    return v > mx ? mx : v < mn ? mn : v;
  endfunction
endpackage

// File: rtl/gba_dsound_if.sv
// gba_dsound_if: MMIO/DMA-side FIFO write, clear, refill request and status bundle
interface gba_dsound_if #(parameter int NUM_CH = 2, parameter int DEPTH = 8);
  localparam int LVL_W = $clog2(DEPTH + 1);
  logic [NUM_CH-1:0] fifo_we, ch_clr, dma_req, underrun, overflow;
  logic [31:0] fifo_wdata;
  logic [NUM_CH*LVL_W-1:0] fifo_level;
  modport master(output fifo_we, fifo_wdata, ch_clr, input dma_req, fifo_level, underrun, overflow);
  modport slave(input fifo_we, fifo_wdata, ch_clr, output dma_req, fifo_level, underrun, overflow);
endinterface

// File: rtl/gba_dsound_chan.sv
// gba_dsound_chan: one PCM channel FIFO + byte sequencer; DSOUND_UNDERRUN_ZERO_EN silences on underrun
module gba_dsound_chan import gba_dsound_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [31:0]      wdata,
  input  logic             clr,
  input  logic             tick,
  output logic             dma_req,
  output logic             underrun,
  output logic             overflow,
  output logic             upd,
  output logic [LVL_W-1:0] level,
  output logic [7:0]       sample_nxt
);
`ifdef DSOUND_UNDERRUN_ZERO_EN
  localparam bit UZ = 1'b1;
`else
  localparam bit UZ = 1'b0;
`endif
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic [31:0] cur_q, cur_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] smp_q, smp_d;
  logic vld_q, vld_d, und_q, und_d, ovf_q, ovf_d, dma_q, dma_d;
  logic empty, full, fetch, pop, adv, urun, push;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == LVL_W'(DEPTH);
    fetch = tick && (idx_q == 2'd0 || !vld_q);
    pop = !clr && fetch && !empty;
    adv = !clr && tick && !fetch;
    urun = !clr && fetch && empty;
    push = !clr && we && (!full || pop);
    rd_d = clr ? '0 : rd_q + AW'(pop);
    wr_d = clr ? '0 : wr_q + AW'(push);
    cnt_d = clr ? '0 : cnt_q + LVL_W'(push) - LVL_W'(pop);
    cur_d = pop ? mem_q[rd_q] : cur_q;
    idx_d = (clr || urun) ? 2'd0 : pop ? 2'd1 : adv ? idx_q + 2'd1 : idx_q;
    vld_d = !(clr || urun) && (pop || vld_q);
    smp_d = (clr || (urun && UZ)) ? 8'h00 : pop ? mem_q[rd_q][7:0] : adv ? byte_sel(cur_q, idx_q) : smp_q;
    und_d = !clr && (und_q || urun);
    ovf_d = !clr && (ovf_q || (we && full && !pop));
    dma_d = pop && cnt_d <= LVL_W'(DEPTH / 2);
    upd = clr || pop || adv || (urun && UZ);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      cur_q <= '0;
      idx_q <= '0;
      smp_q <= '0;
      vld_q <= 1'b0;
      und_q <= 1'b0;
      ovf_q <= 1'b0;
      dma_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      idx_q <= idx_d;
      smp_q <= smp_d;
      vld_q <= vld_d;
      und_q <= und_d;
      ovf_q <= ovf_d;
      dma_q <= dma_d;
    end
  end
  assign dma_req = dma_q;
  assign underrun = und_q;
  assign overflow = ovf_q;
  assign level = cnt_q;
  assign sample_nxt = smp_d;
endmodule

// File: rtl/gba_dsound_engine.sv
// gba_dsound_engine: NUM_CH FIFO-fed PCM channels, timer tick select, registered saturating stereo mix
module gba_dsound_engine import gba_dsound_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int DEPTH = 8,
  parameter int NUM_TIMERS = 2,
  parameter int OUT_W = 16,
  localparam int TSEL_W = tsel_w(NUM_TIMERS),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                     gba_clk,
  input  logic                     reset,
  gba_dsound_if.slave              bus,
  input  logic [NUM_TIMERS-1:0]    timer_ovf,
  input  logic [NUM_CH*TSEL_W-1:0] ch_tsel,
  input  logic [NUM_CH-1:0]        ch_full_vol,
  input  logic [NUM_CH-1:0]        ch_en_l,
  input  logic [NUM_CH-1:0]        ch_en_r,
  output logic signed [OUT_W-1:0]  out_l,
  output logic signed [OUT_W-1:0]  out_r,
  output logic                     out_valid
);
  localparam int NTP = 1 << TSEL_W;
  logic [NTP-1:0] tovf;
  logic [NUM_CH-1:0] tick, upd_v, dma_v, und_v, ovf_v;
  logic [NUM_CH*LVL_W-1:0] lvl_v;
  logic [7:0] smp [NUM_CH];
  logic signed [OUT_W+3:0] sum_l, sum_r, v;
  logic signed [31:0] sl, sr;
  logic signed [OUT_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic valid_q, valid_d;
  assign tovf = NTP'(timer_ovf);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign tick[c] = tovf[ch_tsel[c*TSEL_W +: TSEL_W]];
    gba_dsound_chan #(.DEPTH(DEPTH)) u_chan (
      .clk(gba_clk),
      .rst(reset),
      .we(bus.fifo_we[c]),
      .wdata(bus.fifo_wdata),
      .clr(bus.ch_clr[c]),
      .tick(tick[c]),
      .dma_req(dma_v[c]),
      .underrun(und_v[c]),
      .overflow(ovf_v[c]),
      .upd(upd_v[c]),
      .level(lvl_v[c*LVL_W +: LVL_W]),
      .sample_nxt(smp[c])
    );
  end
  assign bus.dma_req = dma_v;
  assign bus.underrun = und_v;
  assign bus.overflow = ovf_v;
  assign bus.fifo_level = lvl_v;
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v = (OUT_W+4)'(vol_scale(smp[c], ch_full_vol[c]));
      sum_l = sum_l + (ch_en_l[c] ? v : '0);
      sum_r = sum_r + (ch_en_r[c] ? v : '0);
    end
    sl = sat(32'(sum_l), OUT_W);
    sr = sat(32'(sum_r), OUT_W);
    valid_d = |upd_v;
    out_l_d = valid_d ? sl[OUT_W-1:0] : out_l_q;
    out_r_d = valid_d ? sr[OUT_W-1:0] : out_r_q;
  end
  always_ff @(posedge gba_clk) begin
    if (reset) begin
      out_l_q <= '0;
      out_r_q <= '0;
      valid_q <= 1'b0;
    end else begin
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      valid_q <= valid_d;
    end
  end
  assign out_l = out_l_q;
  assign out_r = out_r_q;
  assign out_valid = valid_q;
endmodule
